// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: arbitration modes, FSM encoding and width helper shared by the mux
package rr_arb_mux_pkg;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_e;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: combinational request+pointer to one-hot grant and binary index
module rr_arbiter import rr_arb_mux_pkg::*; #(
    parameter  int N_CH     = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SELW     = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [SELW-1:0] idx
);
    logic [SELW-1:0]   start;
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [SELW:0]     off;
    logic [SELW:0]     sum;

    // Rotate so the search origin sits at bit 0, then pick the lowest set bit
    always_comb begin
        start = (ARB_MODE == ARB_FIXED) ? '0 : ptr;
        dbl   = {req, req} >> start;
        rot   = dbl[N_CH-1:0];
        off   = '0;
        for (int i = N_CH - 1; i >= 0; i--) if (rot[i]) off = (SELW+1)'(i);
        sum   = off + {1'b0, start};
        idx   = (sum >= (SELW+1)'(N_CH)) ? SELW'(sum - (SELW+1)'(N_CH)) : SELW'(sum);
        gnt   = (|req) ? (N_CH'(1) << idx) : '0;
    end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel registered arbitrating multiplexer with packet lock on last
module rr_arb_mux import rr_arb_mux_pkg::*; #(
    parameter  int N_CH     = 4,
    parameter  int WIDTH    = 32,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SELW     = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SELW-1:0]       out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);
    state_e            state_q, state_d;
    logic [SELW-1:0]   lock_ch_q, lock_ch_d, rr_ptr_q, rr_ptr_d, out_sel_q, out_sel_d;
    logic [SELW-1:0]   arb_idx, gidx;
    logic [N_CH-1:0]   arb_gnt, grant;
    logic [WIDTH-1:0]  out_data_q, out_data_d, sel_data;
    logic              out_last_q, out_last_d, out_valid_q, out_valid_d;
    logic              slot_free, accept, sel_last;

    rr_arbiter #(.N_CH(N_CH), .ARB_MODE(ARB_MODE)) u_arb (
        .req(in_valid),
        .ptr(rr_ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    always_comb begin
        slot_free   = ~out_valid_q | out_ready;
        grant       = rst ? '0 : (state_q == ST_LOCK) ? ((N_CH'(1) << lock_ch_q) & in_valid) : arb_gnt;
        gidx        = (state_q == ST_LOCK) ? lock_ch_q : arb_idx;
        in_ready    = grant & {N_CH{slot_free}};
        accept      = |in_ready;
        sel_data    = '0;
        for (int i = 0; i < N_CH; i++) sel_data |= in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}};
        sel_last    = |(grant & in_last);
        state_d     = accept ? (sel_last ? ST_ARB : ST_LOCK) : state_q;
        lock_ch_d   = accept ? gidx : lock_ch_q;
        // Pointer only advances when a packet completes, so it never moves mid-packet
        rr_ptr_d    = (ARB_MODE == ARB_RR && accept && sel_last)
                    ? ((gidx == SELW'(N_CH - 1)) ? '0 : gidx + SELW'(1)) : rr_ptr_q;
        out_valid_d = accept | (out_valid_q & ~out_ready);
        out_data_d  = accept ? sel_data : out_data_q;
        out_last_d  = accept ? sel_last : out_last_q;
        out_sel_d   = accept ? gidx : out_sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
endmodule
